fetch_ctrl: RTL and testbench

Program-sequencing controller sitting directly upstream of the instruction fetch (PC) stage. It decodes the current 9-bit instruction word into the fetch stage's branch controls, jump target pointer and Done flag. It holds the registered Zero condition flag, runs the start/halt handshake with the testbench or host, and counts execution cycles, with a watchdog timeout.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_ctrl_if.sv | 34 +++
 rtl/jump_lut.sv | 14 +
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared opcode/funct codes, FSM states and jump table
// for the program-sequencing controller.
package fetch_pkg;

  localparam logic [2:0] OP_ALU_MAX = 3'b101;
  localparam logic [2:0] OP_CTRL    = 3'b110;
  localparam logic [2:0] OP_MOV     = 3'b111;

  localparam logic [1:0] F_BEZ  = 2'b00;
  localparam logic [1:0] F_BNZ  = 2'b01;
  localparam logic [1:0] F_BA   = 2'b10;
  localparam logic [1:0] F_HALT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE
  } state_t;

  // Entries are stored wide and cut to W bits at lookup.
  localparam int LUT_W = 16;
  localparam logic [LUT_W-1:0] JUMP_LUT [16] = '{
    16'h0000, 16'h0014, 16'h0022, 16'h0037,
    16'h0041, 16'h005A, 16'h0066, 16'h007C,
    16'h0083, 16'h0095, 16'h00A8, 16'h00B1,
    16'h00C6, 16'h00D3, 16'h00E9, 16'h00FE
  };

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus between host/instruction memory and the
// sequencing controller.
interface fetch_ctrl_if #(
  parameter int W  = 8,
  parameter int CW = 16
);
  logic          Start;
  logic [8:0]    Instruction;
  logic          AluZero;
  logic          PcReset;
  logic          BranchEZ;
  logic          BranchNZ;
  logic          BranchAlways;
  logic          Zero;
  logic [W-1:0]  Target;
  logic          Done;
  logic          Ack;
  logic          Timeout;
  logic [CW-1:0] CycleCount;

  modport master (
    output Start, Instruction, AluZero,
    input  PcReset, BranchEZ, BranchNZ,
    input  BranchAlways, Zero, Target,
    input  Done, Ack, Timeout, CycleCount
  );

  modport slave (
    input  Start, Instruction, AluZero,
    output PcReset, BranchEZ, BranchNZ,
    output BranchAlways, Zero, Target,
    output Done, Ack, Timeout, CycleCount
  );
endinterface

// File: rtl/jump_lut.sv
// Combinational 4-bit index to W-bit jump target.
// Wider targets are zero-extended from the table.
module jump_lut
  import fetch_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   i_idx,
  output logic [W-1:0] o_target
);

  assign o_target = W'(JUMP_LUT[i_idx]);

endmodule

// File: rtl/fetch_ctrl.sv
// Program sequencer: decodes branch/halt controls,
// holds the Zero flag, cycle counter and watchdog.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int            W          = 8,
  parameter int            CW         = 16,
  parameter logic [CW-1:0] MAX_CYCLES = CW'(16'hFFFF)
) (
  input logic        Clk,
  input logic        Reset,
  fetch_ctrl_if.slave bus
);

  state_t        r_state;
  state_t        w_next;
  logic          r_zero;
  logic [CW-1:0] r_cnt;
  logic          r_to;

  logic [2:0]    w_op;
  logic [1:0]    w_fn;
  logic          w_run;
  logic          w_ctrl;
  logic          w_halt;
  logic          w_alu;
  logic [CW-1:0] w_cnt_inc;
  logic          w_wd;
  logic          w_to_fire;
  logic [W-1:0]  w_target;

  assign w_op   = bus.Instruction[8:6];
  assign w_fn   = bus.Instruction[5:4];
  assign w_run  = (r_state == S_RUN);
  assign w_ctrl = w_run && (w_op == OP_CTRL);
  assign w_halt = w_ctrl && (w_fn == F_HALT);
  assign w_alu  = w_run && (w_op <= OP_ALU_MAX);

  // Saturating increment; watchdog trips on the
  // RUN cycle that brings the count to the limit.
  assign w_cnt_inc = (&r_cnt) ? r_cnt
                              : r_cnt + 1'b1;
  assign w_wd = (MAX_CYCLES != '0) &&
                (w_cnt_inc == MAX_CYCLES);

  jump_lut #(.W(W)) u_lut (
    .i_idx    (bus.Instruction[3:0]),
    .o_target (w_target)
  );

  // Next-state decode; HALT beats the watchdog.
  always_comb begin
    w_next    = r_state;
    w_to_fire = 1'b0;
    unique case (r_state)
      S_IDLE:   if (bus.Start) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_RUN;
      S_RUN: begin
        if (w_halt) begin
          w_next = S_DONE;
        end else if (w_wd) begin
          w_next    = S_DONE;
          w_to_fire = 1'b1;
        end
      end
      S_DONE:   if (bus.Start) w_next = S_LAUNCH;
      default:  w_next = S_IDLE;
    endcase
  end

  // State, flag, counter and timeout registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_zero  <= 1'b0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LAUNCH) begin
        r_zero <= 1'b0;
        r_cnt  <= '0;
        r_to   <= 1'b0;
      end else if (w_run) begin
        if (w_alu) r_zero <= bus.AluZero;
        r_cnt <= w_cnt_inc;
        if (w_to_fire) r_to <= 1'b1;
      end
    end
  end

  assign bus.PcReset      = Reset ||
                            (r_state == S_LAUNCH);
  assign bus.Done         = !w_run || w_halt;
  assign bus.BranchEZ     = w_ctrl && (w_fn == F_BEZ);
  assign bus.BranchNZ     = w_ctrl && (w_fn == F_BNZ);
  assign bus.BranchAlways = w_ctrl && (w_fn == F_BA);
  assign bus.Zero         = r_zero;
  assign bus.Target       = w_target;
  assign bus.Ack          = (r_state == S_DONE);
  assign bus.Timeout      = r_to;
  assign bus.CycleCount   = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed + random bench for fetch_ctrl against a
// run-level reference model (watchdog limit 8).
module tb_fetch_ctrl;

  localparam int LIM = 8;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  fetch_ctrl_if #(.W(8), .CW(16)) bus ();

  fetch_ctrl #(
    .W(8), .CW(16), .MAX_CYCLES(16'(LIM))
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 launch, 2 run, 3 done.
  int phase = 0;
  bit m_zero = 0;
  bit m_to = 0;
  int m_cnt = 0;

  logic [7:0] lut [16] = '{
    8'h00, 8'h14, 8'h22, 8'h37,
    8'h41, 8'h5A, 8'h66, 8'h7C,
    8'h83, 8'h95, 8'hA8, 8'hB1,
    8'hC6, 8'hD3, 8'hE9, 8'hFE
  };

  function automatic logic [8:0] ins(
    input int op, input int fn, input int idx
  );
    logic [8:0] v;
    v = {3'(op), 2'(fn), 4'(idx)};
    return v;
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(
    input bit rst, input bit st,
    input logic [8:0] i, input bit az
  );
    int op, fn, nc;
    bit run, ctl, halt;
    Reset = rst;
    bus.Start = st;
    bus.Instruction = i;
    bus.AluZero = az;
    #1;
    op   = int'(i[8:6]);
    fn   = int'(i[5:4]);
    run  = (phase == 2);
    ctl  = run && op == 6;
    halt = ctl && fn == 3;
    chk("pcreset", 32'(bus.PcReset),
        32'(rst || phase == 1));
    chk("done", 32'(bus.Done), 32'(!run || halt));
    chk("bez", 32'(bus.BranchEZ), 32'(ctl && fn == 0));
    chk("bnz", 32'(bus.BranchNZ), 32'(ctl && fn == 1));
    chk("ba", 32'(bus.BranchAlways),
        32'(ctl && fn == 2));
    chk("target", 32'(bus.Target),
        32'(lut[i[3:0]]));
    chk("ack", 32'(bus.Ack), 32'(phase == 3));
    chk("zero", 32'(bus.Zero), 32'(m_zero));
    chk("timeout", 32'(bus.Timeout), 32'(m_to));
    chk("cycles", 32'(bus.CycleCount), 32'(m_cnt));
    @(posedge Clk);
    if (rst) begin
      phase = 0; m_zero = 0; m_to = 0; m_cnt = 0;
    end else if (phase == 0 || phase == 3) begin
      if (st) phase = 1;
    end else if (phase == 1) begin
      phase = 2; m_zero = 0; m_to = 0; m_cnt = 0;
    end else begin
      if (op <= 5) m_zero = az;
      nc = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
      m_cnt = nc;
      if (halt) phase = 3;
      else if (nc == LIM) begin
        phase = 3; m_to = 1;
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.Instruction = '0;
    bus.AluZero = 1'b0;
    @(posedge Clk);
    @(negedge Clk);

    cyc(1, 0, ins(0, 0, 0), 0);
    cyc(1, 0, ins(0, 0, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    cyc(0, 1, ins(0, 0, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    // flag/branch program
    cyc(0, 0, ins(0, 1, 5), 1);
    cyc(0, 0, ins(6, 0, 3), 0);
    cyc(0, 0, ins(1, 2, 7), 0);
    cyc(0, 0, ins(6, 1, 9), 1);
    cyc(0, 0, ins(7, 0, 2), 1);
    cyc(0, 0, ins(6, 2, 15), 1);
    cyc(0, 0, ins(6, 3, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    // relaunch, 4 ops then HALT, Start held
    cyc(0, 1, ins(0, 0, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    cyc(0, 0, ins(2, 0, 1), 1);
    cyc(0, 0, ins(3, 0, 4), 0);
    cyc(0, 0, ins(7, 3, 6), 1);
    cyc(0, 0, ins(5, 1, 8), 1);
    cyc(0, 1, ins(6, 3, 10), 0);
    cyc(0, 1, ins(0, 0, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    // BA self-loop until the watchdog fires
    for (int k = 0; k < LIM + 2; k++)
      cyc(0, 0, ins(6, 2, 0), 0);
    // relaunch, HALT on the limit cycle
    cyc(0, 1, ins(0, 0, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    for (int k = 0; k < LIM - 1; k++)
      cyc(0, 0, ins(4, 0, k), 1);
    cyc(0, 0, ins(6, 3, 12), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    // reset mid-run with Start high
    cyc(0, 1, ins(0, 0, 0), 0);
    cyc(0, 1, ins(0, 0, 0), 0);
    cyc(0, 1, ins(1, 0, 0), 1);
    cyc(0, 1, ins(6, 0, 2), 0);
    cyc(1, 1, ins(6, 1, 3), 0);
    cyc(1, 1, ins(0, 0, 0), 0);
    cyc(1, 1, ins(0, 0, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    cyc(0, 0, ins(0, 0, 0), 0);
    // random programs
    for (int k = 0; k < 400; k++) begin
      int op, fn;
      op = int'($urandom_range(7));
      fn = int'($urandom_range(3));
      if (op == 6 && fn == 3 &&
          $urandom_range(3) != 0)
        fn = int'($urandom_range(2));
      cyc(($urandom_range(60) == 0),
          ($urandom_range(3) == 0),
          ins(op, fn, int'($urandom_range(15))),
          bit'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
